// File: rtl/mips32_mem_arbiter_if.sv
// Pipeline/memory bus bundle for the MIPS32 unified-memory arbiter.
// slave = arbiter view; master = pipeline + memory-array view.
interface mips32_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Fetch/data arbiter for a single-ported fixed-latency MIPS32 memory, data-first with fetch
// starvation guard. Optional perf counters under MEMARB_PERF_CNT_EN.
module mips32_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halted,
  mips32_mem_arbiter_if.slave bus
`ifdef MEMARB_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_conflicts,
  output logic [31:0] perf_stalls
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LP_LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_own_d;
  logic          r_own_we;
  logic [3:0]    r_starve_cnt;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;

  logic w_arb, w_eff_if, w_if_win, w_d_win, w_gnt;

  // Arbitration is gated by rst_n so grants/strobes drop the moment reset asserts.
  always_comb begin
    w_arb    = rst_n && (r_state != S_WAIT);
    w_eff_if = bus.if_req & ~halted;
    w_if_win = w_arb & w_eff_if & (~bus.d_req | (r_starve_cnt == LP_STARVE));
    w_d_win  = w_arb & bus.d_req & ~w_if_win;
    w_gnt    = w_if_win | w_d_win;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_gnt) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LP_LAT_M1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_own_d  <= 1'b0;
      r_own_we <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_gnt) begin
        r_own_d  <= w_d_win;
        r_own_we <= w_d_win & bus.d_we;
      end
    end
  end

  // Memory data is valid on the last WAIT cycle; stores leave d_rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (r_state == S_WAIT && r_cnt == 4'd0) begin
      if (!r_own_d)       r_if_rdata <= bus.mem_rdata;
      else if (!r_own_we) r_d_rdata  <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_starve_cnt <= 4'd0;
    else if (!w_eff_if || w_if_win)    r_starve_cnt <= 4'd0;
    else if (w_d_win && r_starve_cnt != LP_STARVE)
                                       r_starve_cnt <= r_starve_cnt + 4'd1;
  end

  assign bus.if_gnt    = w_if_win;
  assign bus.d_gnt     = w_d_win;
  assign bus.mem_en    = w_gnt;
  assign bus.mem_we    = w_d_win & bus.d_we;
  assign bus.mem_addr  = w_if_win ? bus.if_addr : (w_d_win ? bus.d_addr : '0);
  assign bus.mem_wdata = w_d_win ? bus.d_wdata : '0;
  // rvalid follows the registered owner, never the live requests.
  assign bus.if_rvalid = (r_state == S_RESP) & ~r_own_d;
  assign bus.d_rvalid  = (r_state == S_RESP) &  r_own_d;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.busy      = (r_state != S_IDLE);

`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] r_perf_conflicts, r_perf_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_conflicts <= 32'd0;
      r_perf_stalls    <= 32'd0;
    end else if (perf_clr) begin
      r_perf_conflicts <= 32'd0;
      r_perf_stalls    <= 32'd0;
    end else begin
      if (w_arb & w_eff_if & bus.d_req)
        r_perf_conflicts <= r_perf_conflicts + 32'd1;
      if ((bus.if_req & ~w_if_win) | (bus.d_req & ~w_d_win))
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_conflicts = r_perf_conflicts;
  assign perf_stalls    = r_perf_stalls;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed self-checking bench for mips32_mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mips32_mem_arbiter;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic halted;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.AW(32), .DW(32)) bus();

  mips32_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .bus(bus.slave)
  );

  // Memory model: reads appear on mem_rdata MEM_LAT cycles after mem_en.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [1:MEM_LAT];
  always @(posedge clk) begin
    rd_pipe[1] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : 32'hDEAD_BEEF;
    for (int i = 2; i <= MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT];

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; halted = 0; idle_inputs();
    repeat (2) next_cyc();
    #2;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.busy,
         bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      errors++; $display("FAIL rst_outputs: got nonzero outputs, expected all 0");
    end
    checks++;
    if (dut.r_starve_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_starve: got %0d expected 0", dut.r_starve_cnt);
    end
    next_cyc(); rst_n = 1;
    next_cyc();
  endtask

  task automatic test_fetch_alone();
    next_cyc(); bus.if_req = 1; bus.if_addr = 32'h5; #2;
    checks++;
    if ({bus.if_gnt, bus.mem_en, bus.busy} !== 3'b110 || bus.mem_addr !== 32'h5) begin
      errors++; $display("FAIL fa_grant: got gnt/en/busy=%b addr=%h expected 110 addr=5",
                         {bus.if_gnt, bus.mem_en, bus.busy}, bus.mem_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cyc(); bus.if_req = 0; #2;
      checks++;
      if (bus.busy !== (c <= 3) || bus.if_rvalid !== (c == 3)) begin
        errors++; $display("FAIL fa_cyc%0d: got busy=%b rvalid=%b expected busy=%b rvalid=%b",
                           c, bus.busy, bus.if_rvalid, c <= 3, c == 3);
      end
      if (c == 3) begin
        checks++;
        if (bus.if_rdata !== 32'h1443_1000) begin
          errors++; $display("FAIL fa_rdata: got %h expected 14431000", bus.if_rdata);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    next_cyc();
    bus.if_req = 1; bus.if_addr = 32'd16; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd200; #2;
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.mem_addr !== 32'd200) begin
      errors++; $display("FAIL sim_c0: got dgnt=%b ifgnt=%b addr=%0d expected 1 0 200",
                         bus.d_gnt, bus.if_gnt, bus.mem_addr);
    end
    next_cyc(); bus.d_req = 0; #2;
    checks++;
    if (dut.r_starve_cnt !== 4'd1) begin
      errors++; $display("FAIL sim_starve1: got %0d expected 1", dut.r_starve_cnt);
    end
    next_cyc(); next_cyc(); #2;
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFE_0001 || bus.if_gnt !== 1'b1 ||
        bus.mem_addr !== 32'd16) begin
      errors++; $display("FAIL sim_c3: got drv=%b drd=%h ifgnt=%b addr=%0d expected 1 cafe0001 1 16",
                         bus.d_rvalid, bus.d_rdata, bus.if_gnt, bus.mem_addr);
    end
    next_cyc(); bus.if_req = 0; #2;
    checks++;
    if (dut.r_starve_cnt !== 4'd0) begin
      errors++; $display("FAIL sim_starve0: got %0d expected 0", dut.r_starve_cnt);
    end
    next_cyc(); next_cyc(); #2;
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h3C01_0001 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL sim_c6: got ifrv=%b ifrd=%h drv=%b expected 1 3c010001 0",
                         bus.if_rvalid, bus.if_rdata, bus.d_rvalid);
    end
    next_cyc();
  endtask

  task automatic test_starvation();
    next_cyc();
    bus.if_req = 1; bus.if_addr = 32'd16; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd100;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) next_cyc();
      #2;
      if (c % 3 == 0) begin
        checks++;
        if (bus.if_gnt !== (c == 12) || bus.d_gnt !== (c != 12)) begin
          errors++; $display("FAIL starve_arb%0d: got ifgnt=%b dgnt=%b expected %b %b",
                             c, bus.if_gnt, bus.d_gnt, c == 12, c != 12);
        end
      end
    end
    checks++;
    if (dut.r_starve_cnt !== 4'd4) begin
      errors++; $display("FAIL starve_sat: got %0d expected 4", dut.r_starve_cnt);
    end
    next_cyc(); idle_inputs(); #2;
    checks++;
    if (dut.r_starve_cnt !== 4'd0) begin
      errors++; $display("FAIL starve_clr: got %0d expected 0", dut.r_starve_cnt);
    end
    repeat (3) next_cyc();
  endtask

  task automatic test_store();
    next_cyc();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'd198; bus.d_wdata = 32'd40320; #2;
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd198 ||
        bus.mem_wdata !== 32'd40320) begin
      errors++; $display("FAIL st_grant: got gnt=%b we=%b addr=%0d wdata=%0d expected 1 1 198 40320",
                         bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    next_cyc(); idle_inputs();
    next_cyc(); next_cyc(); #2;
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h64) begin
      errors++; $display("FAIL st_ack: got rvalid=%b rdata=%h expected 1 00000064",
                         bus.d_rvalid, bus.d_rdata);
    end
    next_cyc();
  endtask

  task automatic test_halted();
    int bad = 0;
    next_cyc();
    halted = 1; bus.if_req = 1; bus.if_addr = 32'h5;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cyc();
      bus.d_req = (c == 5); bus.d_we = 0; bus.d_addr = 32'd200;
      #2;
      if (bus.if_gnt !== 1'b0) bad++;
      if (c == 5) begin
        checks++;
        if (bus.d_gnt !== 1'b1) begin
          errors++; $display("FAIL halt_dgnt: got %b expected 1", bus.d_gnt);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFE_0001) begin
          errors++; $display("FAIL halt_drv: got %b %h expected 1 cafe0001", bus.d_rvalid, bus.d_rdata);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_no_ifgnt: got %0d fetch grants expected 0", bad);
    end
    next_cyc(); halted = 0; idle_inputs();
    next_cyc(); bus.if_req = 1; bus.if_addr = 32'h6; #2;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++; $display("FAIL halt_race_gnt: got %b expected 1", bus.if_gnt);
    end
    next_cyc(); bus.if_req = 0; halted = 1;
    next_cyc(); next_cyc(); #2;
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h8C22_0004) begin
      errors++; $display("FAIL halt_race_rv: got %b %h expected 1 8c220004", bus.if_rvalid, bus.if_rdata);
    end
    next_cyc(); halted = 0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    next_cyc(); bus.if_req = 1; bus.if_addr = 32'd16; #2;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++; $display("FAIL rm_gnt: got %b expected 1", bus.if_gnt);
    end
    next_cyc(); rst_n = 0; bus.d_req = 1; bus.d_addr = 32'd200; #2;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.busy,
         bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      errors++; $display("FAIL rm_outputs: got gnt=%b/%b en=%b busy=%b ifrd=%h expected all 0",
                         bus.if_gnt, bus.d_gnt, bus.mem_en, bus.busy, bus.if_rdata);
    end
    next_cyc(); rst_n = 1; idle_inputs();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cyc();
      #2;
      if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rm_no_rvalid: got %0d bad cycles expected 0", bad);
    end
    next_cyc(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd200; #2;
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rm_regrant: got gnt=%b busy=%b expected 1 0", bus.d_gnt, bus.busy);
    end
    next_cyc(); idle_inputs();
    next_cyc(); next_cyc(); #2;
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFE_0001) begin
      errors++; $display("FAIL rm_rvalid: got %b %h expected 1 cafe0001", bus.d_rvalid, bus.d_rdata);
    end
    next_cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]   = 32'h1443_1000;
    mem[6]   = 32'h8C22_0004;
    mem[16]  = 32'h3C01_0001;
    mem[100] = 32'h0000_0064;
    mem[200] = 32'hCAFE_0001;
    test_reset();
    test_fetch_alone();
    test_simultaneous();
    test_starvation();
    test_store();
    test_halted();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Arbitrates the single-ported unified MIPS32 memory between two requesters: the instruction-fetch port (IF stage) and the data port (MEM stage, LW/SW).
- One transaction outstanding at a time. Fixed-latency memory.
- Data port has default priority. A starvation counter guarantees fetch progress.
- Sits between the pipeline and the memory array; also quiesces fetch when the core is HALTED.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 2: memory read latency in cycles, legal 1..15.
- STARVE_MAX, 4: consecutive lost fetch arbitrations before fetch is forced to win, legal 1..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halted  in  1  core halted; masks if_req.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  transaction outstanding.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; starve_cnt 0.
  - Assertion mid-transaction aborts it. No rvalid is issued afterwards.
- FSM states:
  - IDLE: arbitrate.
  - WAIT: count down MEM_LAT.
  - RESP: issue rvalid; arbitration is also permitted in RESP.
- Arbitration (IDLE or RESP only; combinational within the cycle):
  - eff_if = if_req & ~halted.
  - Fetch wins if eff_if & (~d_req | starve_cnt == STARVE_MAX). Otherwise the data port wins if d_req.
  - The winner's gnt, mem_en, mem_we (= d_we for data, 0 for fetch), mem_addr and mem_wdata are driven in the same cycle.
  - The loser sees gnt = 0 and must keep its request stable.
  - mem_en/mem_addr are 0 when there is no grant.
- Grant timing and transitions:
  - Grant in cycle T → WAIT. busy = 1 from T+1 until the RESP cycle inclusive.
  - Memory returns data in cycle T+MEM_LAT. The arbiter registers it.
  - RESP is cycle T+MEM_LAT+1: the owner's rvalid pulses for 1 cycle with rdata.
  - RESP → WAIT on a new grant; RESP → IDLE otherwise.
  - Throughput: one access per MEM_LAT+1 cycles.
- Store: d_rvalid still pulses at T+MEM_LAT+1 as the ack; d_rdata holds its previous value.
- rdata hold: if_rdata/d_rdata hold their last value until the next response to that port.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each arbitration cycle where eff_if = 1 and data wins.
  - Clears when fetch is granted, or when eff_if = 0.
- halted:
  - Rising mid-transaction does not cancel an in-flight fetch; its rvalid is still delivered.
  - No new fetch grants while halted = 1.
- Simultaneous requests in a RESP cycle: the new grant and the old rvalid coexist, possibly to different ports.
- Ownership of the in-flight transaction is stored in a register. rvalid is never routed by the current requests.

Optional Feature:
- Macro MEMARB_PERF_CNT_EN.
- When defined: adds outputs perf_conflicts (32 bit; counts arbitration cycles with eff_if & d_req), perf_stalls (32 bit; counts cycles with a req high and no gnt) and input perf_clr (synchronous clear). Counters wrap modulo 2^32 and reset to 0 under rst_n.
- When undefined: none of these ports or registers exist. The remaining behaviour is identical.

Test Plan:
- Fetch alone, MEM_LAT=2:
  - Stimulus: if_req at cycle 0, addr 0x5, memory returns 0x14431000.
  - Required: if_gnt and mem_en in cycle 0; if_rvalid in cycle 3 with if_rdata 0x14431000; busy cycles 1-3.
- Simultaneous requests: if_req and d_req (LW addr 200) at cycle 0.
  - Required: d_gnt in cycle 0, d_rvalid in cycle 3.
  - if_gnt in cycle 3 (same cycle as d_rvalid), if_rvalid in cycle 6.
  - starve_cnt reads 1 then 0.
- Starvation: d_req held high continuously with if_req high, STARVE_MAX=4.
  - Required: fetch loses 4 arbitrations and is granted on the 5th; starve_cnt returns to 0.
- Store to 198 with d_wdata 40320 (8!).
  - Required: mem_we=1, mem_addr=198, mem_wdata=40320 in the grant cycle; d_rvalid ack 3 cycles later; d_rdata unchanged.
- Halted: halted=1 with if_req=1.
  - Required: no if_gnt for 20 cycles; a data request is still served.
  - A fetch granted one cycle before halted rose still returns if_rvalid.
- Reset mid-transaction: rst_n low in the cycle after a grant.
  - Required: all outputs 0 immediately.
  - No rvalid after release; first post-reset request is granted in IDLE with normal latency.
